// File: rtl/spi_rom_pkg.sv
// Shared definitions for the SPI line fetcher: phase encoding, default read
// opcodes and the per-phase SCLK count helper.
package spi_rom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic [7:0]  CMD_SINGLE_DEF = 8'h03;
  localparam logic [7:0]  CMD_QUAD_DEF   = 8'h6B;
  localparam int unsigned CMD_BITS       = 8;

  // Number of clk cycles spent in a phase; single-cycle phases report 1.
  function automatic int unsigned phase_len(input state_e      st,
                                            input logic        quad,
                                            input int unsigned addr_bits,
                                            input int unsigned quad_dummy,
                                            input int unsigned data_clks);
    int unsigned len;
    case (st)
      ST_CMD:   len = CMD_BITS;
      ST_ADDR:  len = addr_bits;
      ST_DUMMY: len = quad ? quad_dummy : 0;
      ST_DATA:  len = data_clks;
      default:  len = 1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_line_bank.sv
// Ping-pong line store: two banks of DATA_CLKS nibbles, nibble or single-bit
// writes into one bank, combinational read of the other; never stalls.
module spi_line_bank
  import spi_rom_pkg::*;
#(
  parameter int DATA_CLKS = 136,
  parameter int NIB_W     = $clog2(DATA_CLKS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic             wr_bit_mode,
  input  logic [NIB_W-1:0] wr_idx,
  input  logic [1:0]       wr_bit_pos,
  input  logic [3:0]       wr_nib,
  input  logic             wr_bit,
  input  logic             rd_bank,
  input  logic [NIB_W-1:0] rd_index,
  output logic [3:0]       rd_nibble
);

  localparam logic [NIB_W:0] DEPTH = (NIB_W + 1)'(DATA_CLKS);

  logic [3:0] mem [2][DATA_CLKS];

  // Contents are don't-care after reset, so the store carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bit_mode) begin
        mem[wr_bank][wr_idx][wr_bit_pos] <= wr_bit;
      end else begin
        mem[wr_bank][wr_idx] <= wr_nib;
      end
    end
  end

  always_comb begin
    rd_nibble = 4'h0;
    if ({1'b0, rd_index} < DEPTH) begin
      rd_nibble = mem[rd_bank][rd_index];
    end
  end

endmodule

// File: rtl/spi_line_fetcher.sv
// SPI/QSPI flash line fetcher: start -> cmd/addr/dummy/data -> done pulse and bank swap,
// cs high 8+ADDR_BITS+dummy+DATA_CLKS cycles; start while busy is dropped, abort returns to idle.
module spi_line_fetcher
  import spi_rom_pkg::*;
#(
  parameter int         DATA_CLKS  = 136,
  parameter int         ADDR_BITS  = 24,
  parameter int         QUAD_DUMMY = 8,
  parameter logic [7:0] CMD_SINGLE = CMD_SINGLE_DEF,
  parameter logic [7:0] CMD_QUAD   = CMD_QUAD_DEF,
  parameter int         NIB_W      = $clog2(DATA_CLKS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode_quad,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 busy,
  output logic                 done,
  output logic                 front_bank,
  input  logic [NIB_W-1:0]     rd_index,
  output logic [3:0]           rd_nibble,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_out0,
  output logic                 spi_dir0,
  input  logic [3:0]           spi_in
);

  localparam int LEN_A   = (ADDR_BITS > DATA_CLKS) ? ADDR_BITS : DATA_CLKS;
  localparam int LEN_B   = (LEN_A > QUAD_DUMMY) ? LEN_A : QUAD_DUMMY;
  localparam int MAX_LEN = (LEN_B > int'(CMD_BITS)) ? LEN_B : int'(CMD_BITS);
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam int SH_W    = int'(CMD_BITS) + ADDR_BITS;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              quad_q, quad_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              out0_q, out0_d;
  logic              dir0_q, dir0_d;
  logic              front_q, front_d;
  logic              last;

  logic              wr_en;
  logic [NIB_W-1:0]  wr_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quad_d  = quad_q;
    sh_d    = sh_q;
    front_d = front_q;
    last    = (cnt_q == CNT_W'(phase_len(state_q, quad_q, ADDR_BITS, QUAD_DUMMY, DATA_CLKS) - 1));

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          quad_d  = mode_quad;
          sh_d    = {(mode_quad ? CMD_QUAD : CMD_SINGLE), addr};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          // The serializer MSB is the bit currently on io0.
          if (state_q == ST_CMD || state_q == ST_ADDR) begin
            sh_d = sh_q << 1;
          end
          if (last) begin
            cnt_d = '0;
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = (quad_q && (QUAD_DUMMY > 0)) ? ST_DUMMY : ST_DATA;
              ST_DUMMY: state_d = ST_DATA;
              default:  state_d = ST_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    if (state_q == ST_DATA && state_d == ST_DONE) begin
      front_d = ~front_q;
    end

    // Outputs are registered from the next state so they change on the same edge as it.
    cs_d   = state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    dir0_d = state_d inside {ST_DUMMY, ST_DATA};
    out0_d = (state_d inside {ST_CMD, ST_ADDR}) ? sh_d[SH_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quad_q  <= 1'b0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      out0_q  <= 1'b0;
      dir0_q  <= 1'b0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quad_q  <= quad_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      out0_q  <= out0_d;
      dir0_q  <= dir0_d;
      front_q <= front_d;
    end
  end

  // Flash launches on the SCLK fall (a clk rise), so the sample at the clk rise ending a DATA cycle is stable.
  assign wr_en  = (state_q == ST_DATA) && !abort;
  assign wr_idx = quad_q ? NIB_W'(cnt_q) : NIB_W'(cnt_q >> 2);

  spi_line_bank #(
    .DATA_CLKS (DATA_CLKS),
    .NIB_W     (NIB_W)
  ) u_bank (
    .clk         (clk),
    .wr_en       (wr_en),
    .wr_bank     (~front_q),
    .wr_bit_mode (~quad_q),
    .wr_idx      (wr_idx),
    .wr_bit_pos  (~cnt_q[1:0]),
    .wr_nib      (spi_in),
    .wr_bit      (spi_in[1]),
    .rd_bank     (front_q),
    .rd_index    (rd_index),
    .rd_nibble   (rd_nibble)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign front_bank = front_q;
  assign spi_cs     = cs_q;
  assign spi_out0   = out0_q;
  assign spi_dir0   = dir0_q;
  assign spi_sclk   = ~clk;

endmodule

// File: doc/spi_line_fetcher.md
Name: spi_line_fetcher

Overview:
Parametrised SPI/QSPI flash line-fetch engine. Generalises the fixed-geometry, hpos-locked VGA ROM reader into a start/done-handshaked fetcher. It supports single (03h) and quad-output (6Bh) reads, a configurable data length, dummy count and address, and a ping-pong line buffer. It sits between the VGA timing/pixel logic, which issues start once per line and reads the front bank by pixel index, and the chip-level SPI pads.

Parameters:
DATA_CLKS, 136, data-phase SCLK cycles per fetch; must be a multiple of 4, ≥4.
ADDR_BITS, 24, address bits sent MSB-first.
QUAD_DUMMY, 8, dummy SCLKs after the address in quad mode (0 in single mode).
CMD_SINGLE, 8'h03, single-read command.
CMD_QUAD, 8'h6B, quad-output read command.
NIB_W, $clog2(DATA_CLKS), width of the nibble read index.

Ports:
clk  in  1  system clock; SCLK derives from it.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request a fetch; sampled on clk rise.
abort  in  1  terminate the current fetch.
mode_quad  in  1  0 = single 03h, 1 = quad 6Bh; latched at start.
addr  in  ADDR_BITS  flash byte address; latched at start.
busy  out  1  high from the cycle after start acceptance through the DONE cycle.
done  out  1  one-cycle pulse when a fetch completes normally.
front_bank  out  1  bank currently presented at rd_nibble.
rd_index  in  NIB_W  nibble index into the front bank.
rd_nibble  out  4  front-bank nibble (combinational); 0 if rd_index ≥ DATA_CLKS.
spi_cs  out  1  chip select, ACTIVE HIGH (parent inverts).
spi_sclk  out  1  ~clk, continuous.
spi_out0  out  1  io0 output (MOSI).
spi_dir0  out  1  io0 direction: 0 = output, 1 = input.
spi_in  in  4  io[3:0] inputs; io1 = MISO.

Behaviour:
- Reset (async, reset_n low) sets all registered outputs: busy = 0, done = 0, spi_cs = 0, spi_out0 = 0, spi_dir0 = 0, front_bank = 0. State = IDLE, counters = 0. Buffer contents are don't-care.
- States:
  - IDLE → CMD when start = 1 and abort = 0. This latches addr and mode_quad. start in any other state is ignored (no queueing).
  - CMD: 8 cycles, spi_out0 = cmd[7-i].
  - ADDR: ADDR_BITS cycles, spi_out0 = addr MSB-first.
  - DUMMY: QUAD_DUMMY cycles, quad mode only; single mode skips it.
  - DATA: DATA_CLKS cycles.
  - DONE: 1 cycle → IDLE.
- spi_cs = 1 exactly in CMD, ADDR, DUMMY and DATA (registered, so it rises on the clk edge after acceptance).
- Total cs-high time = 8 + ADDR_BITS + (quad ? QUAD_DUMMY : 0) + DATA_CLKS cycles. Defaults: 168 cycles single, 176 cycles quad.
- spi_out0 is updated on clk rise and is stable at the following spi_sclk rise. It is 0 outside CMD/ADDR.
- spi_dir0 = 1 in DUMMY and DATA for both modes, and 0 otherwise.
- Capture: the chip launches on the spi_sclk fall, which is a clk rise. Data for DATA cycle k is captured on the clk rise ending cycle k and written to the back bank (~front_bank).
  - Quad: nibble k = spi_in[3:0], io3 = MSB.
  - Single: bit k = spi_in[1], packed MSB-first, so nibble j = bits 4j..4j+3. Only nibbles 0..DATA_CLKS/4−1 are written; higher nibbles keep stale contents.
- DONE cycle: done = 1 and front_bank toggles. rd_nibble therefore shows the new line from the next clk rise.
- abort (any busy state, CMD..DATA): next edge → IDLE, spi_cs = 0, busy = 0, no done pulse, no bank swap. A partially written back bank is allowed. abort in IDLE or DONE is ignored, and DONE still completes.
- abort and start in the same IDLE cycle: abort wins, start is dropped.
- The read port is never blocked; reads of the front bank during a fetch return stable data.
- Reset mid-fetch: immediate cs = 0 and all outputs at reset values.

Decomposition:
- Package spi_rom_pkg: state encoding (IDLE, CMD, ADDR, DUMMY, DATA, DONE), CMD_SINGLE/CMD_QUAD defaults, and the phase-length function `phase_len(state, quad)`.
- One natural sub-module: spi_line_bank, a 2 × DATA_CLKS × 4-bit ping-pong store with nibble/bit write, bank select and combinational read.

Test Plan:
- Reset: hold reset_n low mid-DATA → spi_cs = 0, busy = 0, done = 0, spi_dir0 = 0, front_bank = 0 asynchronously.
- Single fetch, addr = 24'h000120, ROM model returns bytes A5,3C,… → MOSI shows 03h followed by 000120h. cs is high for 168 cycles, done pulses 1 cycle later, front_bank = 1, rd_index 0..3 = A,5,3,C.
- Quad fetch, addr = 24'h001040, ROM model returns nibble k = k mod 16 → MOSI shows 6Bh + addr, spi_dir0 rises after cycle 32, cs is high for 176 cycles, and rd_nibble(k) = k mod 16 for k = 0..135.
- start pulsed at cycles 5 and 50 of a busy fetch → ignored; exactly one done, one swap.
- abort in DATA cycle 60 → cs low next edge, no done, front_bank unchanged, front data intact. Then start → normal completion.
- Back-to-back: start on the cycle after DONE → second fetch fills the other bank, front_bank toggles twice, and rd_index ≥ 136 returns 0.
